// File: rtl/system_bd_button_irq_master.sv
// Services the button PIO edge-capture IRQ: mask write once, read/clear edge_capture, read level, emit event.
// Service latency 2*(READ_LATENCY+1)+2 cycles from IRQ sample; PUSH stalls on event_ready with the bus idle.
module system_bd_button_irq_master #(
    parameter logic [31:0] MASK_VALUE   = 32'd1,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        irq,
    output logic [1:0]  avm_address,
    output logic        avm_chipselect,
    output logic        avm_write_n,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    output logic        event_valid,
    input  logic        event_ready,
    output logic        event_level,
    output logic [15:0] event_count,
    output logic        spurious,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_RD_CAP,
        S_CLR,
        S_RD_LVL,
        S_PUSH
    } state_t;

    localparam logic [1:0] LAT_LOAD = READ_LATENCY[1:0];

    state_t      state_q;
    logic [1:0]  lat_q;
    logic [1:0]  lat_d;
    logic        valid_q;
    logic        level_q;
    logic        spur_q;
    logic [15:0] count_q;
    logic [15:0] count_d;
    logic        lat_done;
    logic        rd_unused;

    assign count_d   = count_q + 16'd1;
    assign lat_d     = lat_q - 2'd1;
    assign lat_done  = (lat_q == 2'd0);
    assign rd_unused = ^avm_readdata[31:1];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_INIT;
            lat_q   <= 2'd0;
            valid_q <= 1'b0;
            level_q <= 1'b0;
            spur_q  <= 1'b0;
            count_q <= 16'd0;
        end else begin
            spur_q <= 1'b0;
            case (state_q)
                S_INIT: state_q <= S_IDLE;
                S_IDLE: begin
                    if (enable && irq) begin
                        state_q <= S_RD_CAP;
                        lat_q   <= LAT_LOAD;
                    end
                end
                S_RD_CAP: begin
                    if (!lat_done) begin
                        lat_q <= lat_d;
                    end else if (avm_readdata[0]) begin
                        state_q <= S_CLR;
                    end else begin
                        // Nothing captured: skip the clear so no edge can be lost.
                        spur_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                S_CLR: begin
                    state_q <= S_RD_LVL;
                    lat_q   <= LAT_LOAD;
                end
                S_RD_LVL: begin
                    if (!lat_done) begin
                        lat_q <= lat_d;
                    end else begin
                        level_q <= avm_readdata[0];
                        valid_q <= 1'b1;
                        state_q <= S_PUSH;
                    end
                end
                S_PUSH: begin
                    if (event_ready) begin
                        count_q <= count_d;
                        valid_q <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_INIT;
            endcase
        end
    end

    // Bus decoded from the registered state; the INIT write is held off while reset is asserted.
    always_comb begin
        avm_address    = 2'd0;
        avm_chipselect = 1'b0;
        avm_write_n    = 1'b1;
        avm_writedata  = 32'd0;
        case (state_q)
            S_INIT: begin
                if (reset_n) begin
                    avm_address    = 2'd2;
                    avm_chipselect = 1'b1;
                    avm_write_n    = 1'b0;
                    avm_writedata  = MASK_VALUE;
                end
            end
            S_RD_CAP: begin
                avm_address    = 2'd3;
                avm_chipselect = 1'b1;
            end
            S_CLR: begin
                avm_address    = 2'd3;
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
            end
            S_RD_LVL: begin
                avm_chipselect = 1'b1;
            end
            default: ;
        endcase
    end

    assign event_valid = valid_q;
    assign event_level = level_q;
    assign event_count = count_q;
    assign spurious    = spur_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_system_bd_button_irq_master.sv
// Bench for system_bd_button_irq_master with a behavioural button PIO and an event scoreboard.
module tb_system_bd_button_irq_master;

    localparam int          RL   = 1;
    localparam logic [31:0] MASK = 32'h0000_0001;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b1;
    logic        irq;
    logic [1:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        event_valid;
    logic        event_ready = 1'b0;
    logic        event_level;
    logic [15:0] event_count;
    logic        spurious;
    logic        busy;

    always #5 clk = ~clk;

    system_bd_button_irq_master #(.MASK_VALUE(MASK), .READ_LATENCY(RL)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .irq(irq),
        .avm_address(avm_address), .avm_chipselect(avm_chipselect),
        .avm_write_n(avm_write_n), .avm_writedata(avm_writedata),
        .avm_readdata(avm_readdata), .event_valid(event_valid),
        .event_ready(event_ready), .event_level(event_level),
        .event_count(event_count), .spurious(spurious), .busy(busy)
    );

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        else passed++;
    endtask

    // Behavioural button PIO: falling-edge capture, write to address 3 clears, registered reads.
    logic        button = 1'b1;
    logic        btn_prev = 1'b1;
    logic        edge_cap = 1'b0;
    logic        force_irq = 1'b0;
    logic [31:0] mask_reg = 32'd0;
    logic [31:0] rd_pipe [RL];
    logic [31:0] reg_val;

    always_comb begin
        case (avm_address)
            2'd0:    reg_val = {31'd0, button};
            2'd2:    reg_val = mask_reg;
            2'd3:    reg_val = {31'd0, edge_cap};
            default: reg_val = 32'd0;
        endcase
    end

    always @(posedge clk) begin
        btn_prev <= button;
        if (btn_prev && !button) edge_cap <= 1'b1;
        else if (avm_chipselect && !avm_write_n && avm_address == 2'd3) edge_cap <= 1'b0;
        if (avm_chipselect && !avm_write_n && avm_address == 2'd2) mask_reg <= avm_writedata;
        rd_pipe[0] <= (avm_chipselect && avm_write_n) ? (($urandom & 32'hFFFF_FFFE) | reg_val) : 32'd0;
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    assign avm_readdata = rd_pipe[RL-1];
    assign irq          = force_irq | (edge_cap & mask_reg[0]);

    // Consumer: 0 = always ready, 1 = random, 2 = stalled.
    int ready_mode = 0;
    initial forever begin
        @(posedge clk);
        #1;
        event_ready = (ready_mode == 0) ? 1'b1 :
                      (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    typedef struct packed {
        logic        level;
        logic [15:0] count;
    } ev_t;

    ev_t         exp_q[$];
    logic [15:0] model_cnt = 16'd0;
    int          wr2_cnt = 0;
    int          wr3_cnt = 0;
    int          spur_cnt = 0;
    logic        hold_prev = 1'b0;
    logic        hold_lvl = 1'b0;

    // Monitor: bus protocol, PUSH stability and event scoreboard.
    always @(negedge clk) begin
        if (!reset_n) begin
            hold_prev = 1'b0;
        end else begin
            if (avm_chipselect && !avm_write_n) begin
                if (avm_address == 2'd2) begin
                    wr2_cnt++;
                    check("mask_wdata", avm_writedata, MASK);
                end else begin
                    wr3_cnt++;
                    check("clr_addr", 32'(avm_address), 32'd3);
                    check("clr_wdata", avm_writedata, 32'd0);
                end
            end
            if (!avm_chipselect) begin
                check("idle_ctl", 32'({avm_address, avm_write_n}), 32'd1);
                check("idle_wdata", avm_writedata, 32'd0);
            end
            if (spurious) spur_cnt++;
            if (event_valid) begin
                check("push_no_bus", 32'(avm_chipselect), 32'd0);
                if (hold_prev) check("push_lvl_stable", 32'(event_level), 32'(hold_lvl));
            end
            if (event_valid && event_ready) begin
                if (exp_q.size() == 0) begin
                    check("evt_expected", 32'(event_valid), 32'd0);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    check("evt_level", 32'(event_level), 32'(e.level));
                    check("evt_count", 32'(event_count), 32'(e.count));
                end
            end
            hold_prev = event_valid && !event_ready;
            hold_lvl  = event_level;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_event(input logic lvl);
        exp_q.push_back('{level: lvl, count: model_cnt});
        model_cnt = model_cnt + 16'd1;
    endtask

    // Falling edge; a level-1 event releases the button straight away.
    task automatic press(input logic lvl);
        expect_event(lvl);
        button = 1'b0;
        tick();
        if (lvl) button = 1'b1;
    endtask

    task automatic wait_drain(input int budget, input int left);
        int n = 0;
        while (exp_q.size() > left && n < budget) begin
            tick();
            n++;
        end
        check("drain", exp_q.size(), left);
        tick();
        tick();
    endtask

    task automatic wait_clr();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(avm_chipselect && !avm_write_n && avm_address == 2'd3) && n < 200);
        check("clr_seen", 32'(n < 200), 32'd1);
    endtask

    initial begin
        logic [4:0]  seq [16];
        logic [4:0]  exp_seq [16];
        int          len;
        int          k;
        bit          seen;
        int          s0, w0, n;
        logic [15:0] c0;
        logic        l0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_cs", 32'(avm_chipselect), 32'd0);
        check("rst_wn", 32'(avm_write_n), 32'd1);
        check("rst_valid", 32'(event_valid), 32'd0);
        check("rst_count", 32'(event_count), 32'd0);
        check("rst_spur", 32'(spurious), 32'd0);

        // Reset release: exactly one mask write.
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        check("init_wr", 32'({avm_chipselect, avm_write_n, avm_address}), 32'b1010);
        @(negedge clk);
        check("init_busy", 32'(busy), 32'd0);
        repeat (4) @(negedge clk);
        check("init_wr_count", 32'(wr2_cnt), 32'd1);

        // Single event, always-ready consumer: bus sequence and latency.
        tick();
        press(1'b0);
        len = 0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) begin
                if (len < 16) seq[len] = {avm_chipselect, avm_write_n, avm_address, event_valid};
                len++;
                seen = 1;
            end else if (seen) begin
                break;
            end
        end
        k = 0;
        for (int i = 0; i <= RL; i++) exp_seq[k++] = 5'b11110;
        exp_seq[k++] = 5'b10110;
        for (int i = 0; i <= RL; i++) exp_seq[k++] = 5'b11000;
        exp_seq[k++] = 5'b01001;
        check("svc_cycles", 32'(len + 1), 32'(2 * RL + 5));
        for (int i = 0; i < k && i < len && i < 16; i++) check("svc_bus", 32'(seq[i]), 32'(exp_seq[i]));
        check("count_one", 32'(event_count), 32'd1);
        check("queue_one", exp_q.size(), 0);
        button = 1'b1;
        tick();

        // Spurious interrupt.
        s0 = spur_cnt;
        w0 = wr3_cnt;
        c0 = event_count;
        force_irq = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!busy && n < 20);
        force_irq = 1'b0;
        repeat (RL + 6) @(negedge clk);
        check("spur_pulses", 32'(spur_cnt - s0), 32'd1);
        check("spur_no_clr", 32'(wr3_cnt - w0), 32'd0);
        check("spur_count", 32'(event_count), 32'(c0));
        check("spur_idle", 32'(busy), 32'd0);
        tick();

        // Backpressure in PUSH.
        ready_mode = 2;
        tick();
        tick();
        press(1'b1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!event_valid && n < 50);
        l0 = event_level;
        c0 = event_count;
        check("bp_level", 32'(l0), 32'd1);
        repeat (10) begin
            @(negedge clk);
            check("bp_valid", 32'(event_valid), 32'd1);
            check("bp_hold_lvl", 32'(event_level), 32'(l0));
        end
        check("bp_count_held", 32'(event_count), 32'(c0));
        ready_mode = 0;
        wait_drain(50, 0);
        check("bp_count_inc", 32'(event_count), 32'(c0 + 16'd1));

        // Second edge right after CLR, enable held high.
        expect_event(1'b1);
        expect_event(1'b0);
        button = 1'b0;
        wait_clr();
        tick();
        button = 1'b1;
        tick();
        button = 1'b0;
        wait_drain(100, 0);
        check("two_evt_count", 32'(event_count), 32'(model_cnt));
        button = 1'b1;
        tick();

        // Second edge with enable dropped: it waits until enable returns.
        expect_event(1'b1);
        expect_event(1'b0);
        button = 1'b0;
        wait_clr();
        enable = 1'b0;
        tick();
        button = 1'b1;
        tick();
        button = 1'b0;
        wait_drain(100, 1);
        repeat (10) tick();
        check("en_blocked_busy", 32'(busy), 32'd0);
        check("en_blocked_count", 32'(event_count), 32'(model_cnt - 16'd1));
        enable = 1'b1;
        wait_drain(100, 0);
        check("en_resume_count", 32'(event_count), 32'(model_cnt));
        button = 1'b1;
        tick();

        // Counter wrap.
        force dut.count_q = 16'hFFFF;
        tick();
        release dut.count_q;
        model_cnt = 16'hFFFF;
        check("wrap_preset", 32'(event_count), 32'h0000_FFFF);
        press(1'b1);
        wait_drain(50, 0);
        check("wrap_zero", 32'(event_count), 32'd0);

        // Reset during RD_LVL.
        press(1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(avm_chipselect && avm_write_n && avm_address == 2'd0) && n < 50);
        check("rdlvl_seen", 32'(n < 50), 32'd1);
        reset_n = 1'b0;
        w0 = wr2_cnt;
        @(negedge clk);
        check("mid_rst_valid", 32'(event_valid), 32'd0);
        check("mid_rst_count", 32'(event_count), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd1);
        check("mid_rst_cs", 32'(avm_chipselect), 32'd0);
        exp_q.delete();
        model_cnt = 16'd0;
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        check("reinit_wr", 32'({avm_chipselect, avm_write_n, avm_address}), 32'b1010);
        tick();
        button = 1'b1;
        repeat (3) tick();
        check("reinit_wr_count", 32'(wr2_cnt - w0), 32'd1);
        check("reinit_idle", 32'(busy), 32'd0);

        // Randomised events with a random-ready consumer.
        ready_mode = 1;
        for (int i = 0; i < 30; i++) begin
            press(1'($urandom_range(0, 1)));
            wait_drain(300, 0);
            button = 1'b1;
            tick();
            repeat ($urandom_range(0, 5)) tick();
        end
        ready_mode = 0;
        tick();
        check("final_count", 32'(event_count), 32'(model_cnt));
        check("final_queue", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/system_bd_button_irq_master.md
Name: system_bd_button_irq_master

Overview:
- Avalon-MM initiator that services the button PIO's edge-capture interrupt in hardware, with no CPU involvement.
- Sequence per interrupt: programs the PIO interrupt mask once after reset, reads edge_capture, clears it, reads the live button level, then hands one event to fabric logic over a valid/ready handshake.
- Sits beside the button PIO in system_bd and drives the PIO's s1 slave port directly.

Parameters:
- MASK_VALUE, 1, value written to PIO address 2 (irq_mask) in INIT.
- READ_LATENCY, 1, cycles from address presentation to valid avm_readdata; legal range 1..3.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  synchronous, active-low reset.
- enable  input  1  1 = service interrupts; 0 = hold in IDLE.
- irq  input  1  PIO interrupt request.
- avm_address  output  2  PIO register address.
- avm_chipselect  output  1  PIO select.
- avm_write_n  output  1  active-low write strobe.
- avm_writedata  output  32  write data.
- avm_readdata  input  32  PIO read data (registered in PIO).
- event_valid  output  1  event available.
- event_ready  input  1  consumer accepts event.
- event_level  output  1  button level sampled after the clear.
- event_count  output  16  accepted-event counter.
- spurious  output  1  one-cycle pulse on spurious interrupt.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (reset_n low at a clk edge):
  - state = INIT; event_valid = 0, event_level = 0, event_count = 0, spurious = 0, busy = 1.
  - Bus idles at address 0, chipselect 0, write_n 1, writedata 0.
  - Reset mid-operation abandons the transaction in the same edge; no partial write is completed.
- Bus idle value, in every state that does not drive the bus: address 0, chipselect 0, write_n 1, writedata 0.
- INIT, 1 cycle: chipselect 1, write_n 0, address 2, writedata = MASK_VALUE. Next state IDLE.
- IDLE:
  - busy 0.
  - If enable && irq, go to RD_CAP; otherwise stay.
  - irq is sampled only in IDLE.
- RD_CAP, READ_LATENCY+1 cycles:
  - chipselect 1, write_n 1, address 3 held constant throughout.
  - avm_readdata[0] is sampled at the end of the final cycle.
  - Sampled bit = 1: next state CLR.
  - Sampled bit = 0 (spurious): pulse spurious for 1 cycle, return to IDLE, no clear write.
- CLR, 1 cycle: chipselect 1, write_n 0, address 3, writedata 0. Next state RD_LVL.
- RD_LVL, READ_LATENCY+1 cycles:
  - Address 0 with chipselect 1, write_n 1.
  - avm_readdata[0] is sampled into event_level at the end of the final cycle.
  - Next state PUSH.
- PUSH:
  - event_valid 1; event_level is stable while valid.
  - On event_valid && event_ready: event_count increments (wraps 0xFFFF -> 0x0000), event_valid drops the next cycle, state goes to IDLE.
  - event_ready high on the first PUSH cycle completes the handshake in 1 cycle.
- Latency counter: up to 2 bits, reloads on entry to each read state.
- enable deasserted mid-service: the current sequence finishes, including PUSH; only new IDLE -> RD_CAP transitions are blocked.
- Edges during service:
  - An edge arriving before CLR is absorbed by that CLR and is not counted.
  - An edge arriving after CLR re-raises irq and is serviced on the next IDLE cycle.
- Backpressure: the PIO edge_capture stays sticky while the block waits in PUSH; no bus activity occurs in PUSH.

Test Plan:
- Reset release -> exactly one write cycle: address 2, writedata 0x00000001; then busy 0, bus idle.
- Button falling edge with READ_LATENCY=1, event_ready tied 1:
  - Bus sequence: read addr 3 for 2 cycles; write addr 3 data 0; read addr 0 for 2 cycles; event_valid high for 1 cycle.
  - event_level = 0, event_count = 1.
  - Total 7 cycles from IDLE irq sample to return to IDLE.
- Force irq=1 while PIO readdata bit0=0 -> spurious pulses once, no write to address 3, event_count unchanged.
- Hold event_ready=0 for 10 cycles in PUSH -> event_valid and event_level stable, no bus activity; release -> count increments once.
- Second edge injected right after CLR -> two events delivered, event_count = 2; with enable=0 at the second edge, the first completes and the second waits until enable returns to 1.
- Preset event_count to 0xFFFF via 65535 events, or force it to 0xFFFF -> next event wraps it to 0x0000.
- Assert reset_n low during RD_LVL -> next cycle in INIT, event_valid 0, counter 0; INIT mask write reissued.
